// File: rtl/md5_core_stream_pkg.sv
// Shared MD5 definitions: IV words, per-step shift/constant tables,
// message word schedule and the controller state encoding.
package md5_core_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] A_INIT = 32'h67452301;
    localparam logic [31:0] B_INIT = 32'hefcdab89;
    localparam logic [31:0] C_INIT = 32'h98badcfe;
    localparam logic [31:0] D_INIT = 32'h10325476;

    localparam logic [4:0] S_TAB [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Schedule offsets only depend on step mod 16, so 4-bit wrap is the mod.
    function automatic logic [3:0] msg_idx(input logic [5:0] step);
        logic [3:0] i;
        i = step[3:0];
        case (step[5:4])
            2'd0:    msg_idx = i;
            2'd1:    msg_idx = i * 4'd5 + 4'd1;
            2'd2:    msg_idx = i * 4'd3 + 4'd5;
            default: msg_idx = i * 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/md5_core_stream_round.sv
// One MD5 step: returns the new B word (b + rotl(F + a + K + M, s)).
// Purely combinational; the caller performs the A/B/C/D rotation.
module md5round (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] m_i,
    input  logic [4:0]  s_i,
    input  logic [31:0] t_i,
    input  logic [1:0]  r_i,
    output logic [31:0] next_a_o
);

    logic [31:0] f_w;
    logic [31:0] sum_w;
    logic [63:0] rot_w;

    always_comb begin
        case (r_i)
            2'd0:    f_w = (b_i & c_i) | (~b_i & d_i);
            2'd1:    f_w = (d_i & b_i) | (~d_i & c_i);
            2'd2:    f_w = b_i ^ c_i ^ d_i;
            default: f_w = c_i ^ (b_i | ~d_i);
        endcase
    end

    assign sum_w    = a_i + f_w + t_i + m_i;
    // Upper half of the doubled word is the left rotate.
    assign rot_w    = {sum_w, sum_w} << s_i;
    assign next_a_o = b_i + rot_w[63:32];

endmodule

// File: rtl/md5_core_stream.sv
// Iterative MD5 compression over pre-padded 512-bit blocks, UNROLL (1/2/4)
// steps per clock, hash state chained across blocks, digest held until out_ready.
module md5_core_stream
    import md5_core_stream_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_digest,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    state_e       state_q;
    logic [5:0]   step_q;
    logic [511:0] blk_q;
    logic         first_q, last_q;
    logic [31:0]  wa_q, wb_q, wc_q, wd_q;
    logic [31:0]  ca_q, cb_q, cc_q, cd_q;
    logic         out_valid_q;
    logic [127:0] out_digest_q;

    logic [31:0]  wa_d, wb_d, wc_d, wd_d;
    logic [31:0]  sa_d, sb_d, sc_d, sd_d;
    logic [31:0]  blk_w [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            blk_w[i] = blk_q[32*i +: 32];
        end
    end

    for (genvar u = 0; u < UNROLL; u++) begin : g_step
        logic [5:0]  st;
        logic [31:0] a_in, b_in, c_in, d_in, b_new;

        if (u == 0) begin : g_src
            assign a_in = wa_q;
            assign b_in = wb_q;
            assign c_in = wc_q;
            assign d_in = wd_q;
        end else begin : g_src
            assign a_in = g_step[u-1].d_in;
            assign b_in = g_step[u-1].b_new;
            assign c_in = g_step[u-1].b_in;
            assign d_in = g_step[u-1].c_in;
        end

        assign st = step_q + 6'(u);

        md5round u_round (
            .a_i      (a_in),
            .b_i      (b_in),
            .c_i      (c_in),
            .d_i      (d_in),
            .m_i      (blk_w[msg_idx(st)]),
            .s_i      (S_TAB[st]),
            .t_i      (K_TAB[st]),
            .r_i      (st[5:4]),
            .next_a_o (b_new)
        );
    end

    assign wa_d = g_step[UNROLL-1].d_in;
    assign wb_d = g_step[UNROLL-1].b_new;
    assign wc_d = g_step[UNROLL-1].b_in;
    assign wd_d = g_step[UNROLL-1].c_in;

    // A first block always chains from IV, whatever a restarted message left behind.
    assign sa_d = (first_q ? A_INIT : ca_q) + wa_q;
    assign sb_d = (first_q ? B_INIT : cb_q) + wb_q;
    assign sc_d = (first_q ? C_INIT : cc_q) + wc_q;
    assign sd_d = (first_q ? D_INIT : cd_q) + wd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= 6'd0;
            blk_q        <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            {wa_q, wb_q, wc_q, wd_q} <= '0;
            {ca_q, cb_q, cc_q, cd_q} <= {A_INIT, B_INIT, C_INIT, D_INIT};
            out_valid_q  <= 1'b0;
            out_digest_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk_q   <= in_block;
                        first_q <= in_first;
                        last_q  <= in_last;
                        step_q  <= 6'd0;
                        if (in_first) begin
                            {wa_q, wb_q, wc_q, wd_q} <= {A_INIT, B_INIT, C_INIT, D_INIT};
                        end else begin
                            {wa_q, wb_q, wc_q, wd_q} <= {ca_q, cb_q, cc_q, cd_q};
                        end
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    {wa_q, wb_q, wc_q, wd_q} <= {wa_d, wb_d, wc_d, wd_d};
                    step_q <= step_q + 6'(UNROLL);
                    if (step_q == 6'(64 - UNROLL)) begin
                        state_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    {ca_q, cb_q, cc_q, cd_q} <= {sa_d, sb_d, sc_d, sd_d};
                    if (last_q) begin
                        out_digest_q <= {sa_d, sb_d, sc_d, sd_d};
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        {ca_q, cb_q, cc_q, cd_q} <= {A_INIT, B_INIT, C_INIT, D_INIT};
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_digest = out_digest_q;

endmodule

// File: tb/tb_md5_core_stream.sv
// Bench for md5_core_stream: known digests plus randomized multi-block messages
// checked against a behavioural MD5 model.
module tb_md5_core_stream;

    localparam int UNROLL = 1;
    localparam int LAT    = 64 / UNROLL;
    localparam logic [127:0] IV_T    = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [127:0] EMPTY_D = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] ABC_D   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [127:0] TWO_D   = 128'h07ef1582_ca0ba296_d316e1aa_4a666c87;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_block;
    logic         in_first, in_last, in_valid, in_ready;
    logic [127:0] out_digest;
    logic         out_valid, out_ready, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] kk [64];
    int sh_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    logic [511:0] empty_blk, abc_blk, two_blk1, two_blk2;

    md5_core_stream #(.UNROLL(UNROLL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_block   (in_block),
        .in_first   (in_first),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_digest (out_digest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] md5_ref(input logic [127:0] h, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, tmp;
        int g, s;
        a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;               end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            s   = sh_tab[i / 16][i % 4];
            tmp = a + f + kk[i] + blk[32*g +: 32];
            a = d; d = c; c = b;
            b = b + ((tmp << s) | (tmp >> (32 - s)));
        end
        return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_block(input logic [511:0] b, input logic f, input logic l, output bit ok);
        int w = 0;
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        ok       = in_ready;
        in_block = b;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'($urandom);
        in_last  = 1'($urandom);
        in_block = rand_block();
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_block = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_digest !== 128'd0) begin n_fail++; $display("FAIL reset_digest: got %h want 0", out_digest); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single(input string name, input logic [511:0] blk, input logic [127:0] known);
        bit ok; int lat;
        send_block(blk, 1'b1, 1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_send: in_ready never rose", name); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", name, busy); end
        wait_out(lat, ok);
        n_checks++; if (lat != LAT + 2) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT + 2); end
        n_checks++; if (out_digest !== known) begin n_fail++; $display("FAIL %s_digest: got %h want %h", name, out_digest, known); end
        n_checks++; if (out_digest !== md5_ref(IV_T, blk)) begin n_fail++; $display("FAIL %s_model: got %h want %h", name, out_digest, md5_ref(IV_T, blk)); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_done_in_ready: got %b want 0", name, in_ready); end
        accept_out();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_release: out_valid got %b want 0", name, out_valid); end
    endtask

    task automatic test_two_block();
        bit ok; int lat; int low = 0; int spurious = 0;
        send_block(two_blk1, 1'b1, 1'b0, ok);
        while (!in_ready && low < 300) begin
            if (out_valid) spurious++;
            low++;
            @(negedge clk);
        end
        n_checks++; if (low != LAT + 1) begin n_fail++; $display("FAIL two_gap: in_ready low %0d cycles want %0d", low, LAT + 1); end
        n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL two_spurious: out_valid seen %0d times want 0", spurious); end
        send_block(two_blk2, 1'b0, 1'b1, ok);
        wait_out(lat, ok);
        n_checks++; if (lat != LAT + 2) begin n_fail++; $display("FAIL two_latency: got %0d want %0d", lat, LAT + 2); end
        n_checks++; if (out_digest !== TWO_D) begin n_fail++; $display("FAIL two_digest: got %h want %h", out_digest, TWO_D); end
        n_checks++; if (out_digest !== md5_ref(md5_ref(IV_T, two_blk1), two_blk2)) begin
            n_fail++; $display("FAIL two_model: got %h want %h", out_digest, md5_ref(md5_ref(IV_T, two_blk1), two_blk2));
        end
        accept_out();
    endtask

    task automatic test_backpressure();
        bit ok; int lat;
        send_block(abc_blk, 1'b1, 1'b1, ok);
        wait_out(lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_digest !== ABC_D) begin n_fail++; $display("FAIL bp_digest[%0d]: got %h want %h", i, out_digest, ABC_D); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        accept_out();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        bit ok; int spurious = 0;
        send_block(abc_blk, 1'b1, 1'b1, ok);
        repeat (20 / UNROLL) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_digest !== 128'd0) begin n_fail++; $display("FAIL rmid_digest: got %h want 0", out_digest); end
        repeat (LAT + 10) begin
            if (out_valid) spurious++;
            @(negedge clk);
        end
        n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL rmid_spurious: out_valid seen %0d times want 0", spurious); end
        test_single("rmid_empty", empty_blk, EMPTY_D);
    endtask

    task automatic test_restart();
        bit ok; int lat;
        send_block(rand_block(), 1'b1, 1'b0, ok);
        send_block(abc_blk, 1'b1, 1'b1, ok);
        wait_out(lat, ok);
        n_checks++; if (out_digest !== ABC_D) begin n_fail++; $display("FAIL restart_digest: got %h want %h", out_digest, ABC_D); end
        accept_out();
        // Continuation block after a finished message starts from IV again.
        send_block(abc_blk, 1'b0, 1'b1, ok);
        wait_out(lat, ok);
        n_checks++; if (out_digest !== ABC_D) begin n_fail++; $display("FAIL after_done_digest: got %h want %h", out_digest, ABC_D); end
        accept_out();
    endtask

    task automatic test_out_ready_held();
        bit ok; int lat;
        out_ready = 1'b1;
        send_block(empty_blk, 1'b1, 1'b1, ok);
        wait_out(lat, ok);
        n_checks++; if (out_digest !== EMPTY_D) begin n_fail++; $display("FAIL held_digest: got %h want %h", out_digest, EMPTY_D); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL held_done_len: out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL held_idle: in_ready got %b want 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit ok; int lat; int nblk;
        logic [127:0] h; logic [511:0] blk; logic f;
        for (int msg = 0; msg < 6; msg++) begin
            nblk = $urandom_range(1, 3);
            h = IV_T;
            for (int b = 0; b < nblk; b++) begin
                blk = rand_block();
                f = (b == 0) || ($urandom_range(0, 3) == 0);
                if (f) h = IV_T;
                h = md5_ref(h, blk);
                send_block(blk, f, (b == nblk - 1), ok);
            end
            wait_out(lat, ok);
            n_checks++; if (out_digest !== h) begin n_fail++; $display("FAIL rand_digest[%0d]: got %h want %h", msg, out_digest, h); end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            n_checks++; if (out_digest !== h) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h want %h", msg, out_digest, h); end
            accept_out();
        end
    endtask

    initial begin
        real r;
        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kk[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        empty_blk = '0; empty_blk[31:0] = 32'h00000080;
        abc_blk   = '0; abc_blk[31:0]   = 32'h80636261; abc_blk[14*32 +: 32] = 32'h00000018;
        two_blk1  = '0;
        for (int j = 0; j < 14; j++)
            for (int n = 0; n < 4; n++)
                two_blk1[8*(4*j+n) +: 8] = 8'(8'h61 + j + n);
        two_blk1[8*56 +: 8] = 8'h80;
        two_blk2 = '0; two_blk2[14*32 +: 32] = 32'h000001c0;

        @(negedge clk);
        test_reset();
        test_single("empty", empty_blk, EMPTY_D);
        test_single("abc", abc_blk, ABC_D);
        test_two_block();
        test_backpressure();
        test_reset_mid();
        test_restart();
        test_out_ready_held();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
